sha3_feed: RTL and testbench



---
 rtl/sha3_feed_pkg.sv | 11 +
 rtl/sha3_feed.sv | 119 +++++++++++
 tb/tb_sha3_feed.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_feed_pkg.sv
// sha3_feed_pkg: shared SHA3-512 lane/rate constants and feeder state encoding
package sha3_feed_pkg;
    localparam int LANE_W = 64;
    localparam int SHA3_RATE_LANES = 9;
    localparam int SHA3_RATE_BITS = SHA3_RATE_LANES * LANE_W;
    localparam logic [2:0] SHA3_DOMAIN_PAD = 3'b110;
    typedef enum logic [2:0] {S_IDLE, S_RD, S_LD, S_PAD, S_EMIT, S_FIN} state_t;
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction
endpackage

// File: rtl/sha3_feed.sv
// sha3_feed: packs recovered support vectors into padded SHA3-512 lanes for the absorber
module sha3_feed
    import sha3_feed_pkg::*;
#(
    parameter int M  = 83,
    parameter int R  = 5,
    parameter int AW = $clog2(R)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          e_ren,
    output logic [AW-1:0] e_addr,
    input  logic [M-1:0]  e_rdata,
    output logic [63:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_blast,
    output logic          out_last,
    output logic          busy,
    output logic          done
);
    localparam int L  = R * M;
    localparam int B  = ceil_div(L + 4, SHA3_RATE_BITS);
    localparam int W  = SHA3_RATE_LANES * B;
    localparam int BW = (M - 1 > 3) ? LANE_W + M - 1 : LANE_W + 3;
    localparam int FW = $clog2(BW + 1);
    localparam int LW = $clog2(W + 1);
    localparam int VW = $clog2(R + 1);

    state_t        state_q, state_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [VW-1:0] vidx_q, vidx_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [3:0]    blk_q, blk_d;
    logic          pad_q, pad_d;
    logic          last;

    assign last      = lane_q == LW'(W - 1);
    assign out_valid = state_q == S_EMIT;
    assign out_data  = out_valid ? (buf_q[LANE_W-1:0] | {last, {LANE_W-1{1'b0}}}) : '0;
    assign out_blast = out_valid && blk_q == 4'd8;
    assign out_last  = out_valid && last;
    assign e_ren     = state_q == S_RD;
    assign e_addr    = vidx_q[AW-1:0];
    assign busy      = state_q inside {S_RD, S_LD, S_PAD, S_EMIT};
    assign done      = state_q == S_FIN;

    // next state: load vectors, pad once the message is consumed, drain lanes until the last one
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        fill_d  = fill_q;
        vidx_d  = vidx_q;
        lane_d  = lane_q;
        blk_d   = blk_q;
        pad_d   = pad_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = start ? S_RD : S_IDLE;
                if (start) begin
                    buf_d  = '0;
                    fill_d = '0;
                    vidx_d = '0;
                    lane_d = '0;
                    blk_d  = '0;
                    pad_d  = 1'b0;
                end
            end
            S_RD: state_d = S_LD;
            S_LD: begin
                buf_d   = buf_q | (BW'(e_rdata) << fill_q);
                fill_d  = fill_q + FW'(M);
                vidx_d  = vidx_q + VW'(1);
                state_d = (fill_d >= FW'(LANE_W)) ? S_EMIT : (vidx_d < VW'(R)) ? S_RD : S_PAD;
            end
            S_PAD: begin
                buf_d   = buf_q | (BW'(SHA3_DOMAIN_PAD) << fill_q);
                fill_d  = fill_q + FW'(3);
                pad_d   = 1'b1;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready) begin
                    buf_d   = buf_q >> LANE_W;
                    fill_d  = (fill_q > FW'(LANE_W)) ? fill_q - FW'(LANE_W) : '0;
                    lane_d  = lane_q + LW'(1);
                    blk_d   = (blk_q == 4'd8) ? 4'd0 : blk_q + 4'd1;
                    state_d = last ? S_FIN
                            : (pad_q || fill_d >= FW'(LANE_W)) ? S_EMIT
                            : (vidx_q < VW'(R)) ? S_RD : S_PAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state registers with synchronous reset discarding any partial lane
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            fill_q  <= '0;
            vidx_q  <= '0;
            lane_q  <= '0;
            blk_q   <= '0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            vidx_q  <= vidx_d;
            lane_q  <= lane_d;
            blk_q   <= blk_d;
            pad_q   <= pad_d;
        end
    end
endmodule

// File: tb/tb_sha3_feed.sv
// tb_sha3_feed: scoreboard bench for sha3_feed in default and M=64/R=9 configurations
module tb_sha3_feed;
    typedef struct {
        logic [63:0] d;
        logic        b;
        logic        l;
    } lane_t;

    logic        clk, rst, start0, start1, rdy, sel;
    logic        ren0, ren1, v0, v1, b0, b1, l0, l1, busy0, busy1, done0, done1;
    logic [2:0]  addr0;
    logic [3:0]  addr1;
    logic [82:0] rdata0;
    logic [63:0] rdata1, data0, data1;
    logic [82:0] mem0 [0:7];
    logic [63:0] mem1 [0:15];
    logic        ov, ob, ol, od, obusy;
    logic [63:0] odat;
    lane_t       sb[$];
    int          tests, fails, exp_w;

    sha3_feed dut (
        .clk(clk), .rst(rst), .start(start0), .e_ren(ren0), .e_addr(addr0), .e_rdata(rdata0),
        .out_data(data0), .out_valid(v0), .out_ready(rdy), .out_blast(b0), .out_last(l0),
        .busy(busy0), .done(done0)
    );

    sha3_feed #(.M(64), .R(9)) dut2 (
        .clk(clk), .rst(rst), .start(start1), .e_ren(ren1), .e_addr(addr1), .e_rdata(rdata1),
        .out_data(data1), .out_valid(v1), .out_ready(rdy), .out_blast(b1), .out_last(l1),
        .busy(busy1), .done(done1)
    );

    assign ov    = sel ? v1 : v0;
    assign ob    = sel ? b1 : b0;
    assign ol    = sel ? l1 : l0;
    assign od    = sel ? done1 : done0;
    assign obusy = sel ? busy1 : busy0;
    assign odat  = sel ? data1 : data0;

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [82:0] rnd83();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[82:0];
    endfunction

    always_ff @(posedge clk) begin
        rdata0 <= ren0 ? mem0[addr0] : rnd83();
        rdata1 <= ren1 ? mem1[addr1] : {$urandom(), $urandom()};
    end

    task automatic push_expected();
        int m, r, l, b;
        logic [1151:0] msg;
        m = sel ? 64 : 83;
        r = sel ? 9 : 5;
        l = m * r;
        b = (l + 4 + 575) / 576;
        exp_w = 9 * b;
        msg = '0;
        for (int k = 0; k < l; k++) msg[k] = sel ? mem1[k / m][k % m] : mem0[k / m][k % m];
        msg[l + 1] = 1'b1;
        msg[l + 2] = 1'b1;
        msg[576 * b - 1] = 1'b1;
        for (int i = 0; i < exp_w; i++) sb.push_back('{msg[64 * i +: 64], (i % 9) == 8, i == exp_w - 1});
    endtask

    task automatic run_stream(input bit s, input bit rnd_ready, input bit restart, input string name);
        int hs_cnt, cyc, last_hs, bad_tail;
        bit got_done, stalled, pulse;
        lane_t held, ex;
        hs_cnt = 0; last_hs = -10; stalled = 0; got_done = 0; bad_tail = 0;
        sel = s;
        sb.delete();
        push_expected();
        @(negedge clk);
        rdy = 1'b1; start0 = !s; start1 = s;
        @(negedge clk);
        start0 = 0; start1 = 0; cyc = 1;
        if (!s) begin
            tests++;
            if (ren0 !== 1'b1 || addr0 !== 3'd0) begin
                fails++;
                $display("FAIL %s rd_cycle1: e_ren/e_addr got %b/%0d want 1/0", name, ren0, addr0);
            end
        end
        while (!got_done && cyc < 400) begin
            rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            pulse = restart && (cyc == 5 || cyc == 12);
            start0 = !s && pulse;
            start1 = s && pulse;
            if (stalled) begin
                tests++;
                if (ov !== 1'b1 || odat !== held.d || ob !== held.b || ol !== held.l) begin
                    fails++;
                    $display("FAIL %s stall_hold: got v=%b %h b=%b l=%b want v=1 %h b=%b l=%b",
                             name, ov, odat, ob, ol, held.d, held.b, held.l);
                end
            end
            if (od) begin
                got_done = 1;
                tests++;
                if (sb.size() != 0 || hs_cnt != exp_w || obusy !== 1'b0 || cyc != last_hs + 1) begin
                    fails++;
                    $display("FAIL %s done: left=%0d lanes=%0d busy=%b done_cyc=%0d want left=0 lanes=%0d busy=0 done_cyc=%0d",
                             name, sb.size(), hs_cnt, obusy, cyc, exp_w, last_hs + 1);
                end
                if (!s && !rnd_ready) begin
                    tests++;
                    if (cyc > 2 * 5 + 9 + 4) begin
                        fails++;
                        $display("FAIL %s latency: got %0d cycles want <= %0d", name, cyc, 2 * 5 + 9 + 4);
                    end
                end
            end else if (ov) begin
                held = '{odat, ob, ol};
                stalled = !rdy;
                if (rdy) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL %s extra_lane: got %h want no lane", name, odat);
                    end else begin
                        ex = sb.pop_front();
                        if (odat !== ex.d || ob !== ex.b || ol !== ex.l) begin
                            fails++;
                            $display("FAIL %s lane%0d: got %h b=%b l=%b want %h b=%b l=%b",
                                     name, hs_cnt, odat, ob, ol, ex.d, ex.b, ex.l);
                        end
                    end
                    hs_cnt++;
                    last_hs = cyc;
                end
            end else begin
                stalled = 0;
            end
            @(negedge clk);
            cyc++;
        end
        start0 = 0; start1 = 0; rdy = 1'b1;
        tests++;
        if (!got_done) begin
            fails++;
            $display("FAIL %s timeout: got no done want done within 400 cycles", name);
        end
        repeat (4) begin
            if (ov || od) bad_tail++;
            @(negedge clk);
        end
        tests++;
        if (bad_tail != 0) begin
            fails++;
            $display("FAIL %s quiet_after_done: got %0d active cycles want 0", name, bad_tail);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        tests++;
        if ({v0, b0, l0, ren0, busy0, done0} !== 6'b0 || data0 !== 64'd0 || addr0 !== 3'd0) begin
            fails++;
            $display("FAIL reset_dut: got v=%b b=%b l=%b ren=%b busy=%b done=%b data=%h addr=%0d want all 0",
                     v0, b0, l0, ren0, busy0, done0, data0, addr0);
        end
        tests++;
        if ({v1, b1, l1, ren1, busy1, done1} !== 6'b0 || data1 !== 64'd0 || addr1 !== 4'd0) begin
            fails++;
            $display("FAIL reset_dut2: got v=%b b=%b l=%b ren=%b busy=%b done=%b data=%h addr=%0d want all 0",
                     v1, b1, l1, ren1, busy1, done1, data1, addr1);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_all_zero();
        for (int i = 0; i < 8; i++) mem0[i] = '0;
        run_stream(0, 0, 0, "zero");
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < 8; i++) mem0[i] = '1;
        run_stream(0, 0, 0, "ones");
    endtask

    task automatic test_random_ready();
        for (int i = 0; i < 8; i++) mem0[i] = rnd83();
        run_stream(0, 0, 0, "rand_ready_hi");
        run_stream(0, 1, 0, "rand_ready_50");
    endtask

    task automatic test_restart();
        for (int i = 0; i < 8; i++) mem0[i] = rnd83();
        run_stream(0, 0, 1, "restart_ignored");
    endtask

    task automatic test_reset_mid();
        int hs, bad;
        bit hit;
        sel = 0; hs = 0; hit = 0; bad = 0;
        for (int i = 0; i < 8; i++) mem0[i] = rnd83();
        @(negedge clk);
        rdy = 1; start0 = 1;
        @(negedge clk);
        start0 = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (ov) begin
                if (hs == 3) begin
                    rdy = 0;
                    hit = 1;
                end else hs++;
            end
            if (!hit) @(negedge clk);
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL reset_mid_reach: got %0d lanes want lane 3 valid", hs);
        end
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        tests++;
        if (ov !== 1'b0 || obusy !== 1'b0 || od !== 1'b0 || odat !== 64'd0 || ren0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got v=%b busy=%b done=%b data=%h ren=%b want 0",
                     ov, obusy, od, odat, ren0);
        end
        rst = 0; rdy = 1;
        repeat (6) begin
            @(negedge clk);
            if (od || ov || obusy) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_mid_no_done: got %0d active cycles want 0", bad);
        end
        run_stream(0, 0, 0, "after_reset");
    endtask

    task automatic test_wide();
        for (int i = 0; i < 16; i++) mem1[i] = {$urandom(), $urandom()};
        run_stream(1, 0, 0, "wide");
        run_stream(1, 1, 0, "wide_stall");
    endtask

    initial begin
        tests = 0; fails = 0; exp_w = 0;
        rst = 1; start0 = 0; start1 = 0; rdy = 1; sel = 0;
        for (int i = 0; i < 8; i++) mem0[i] = '0;
        for (int i = 0; i < 16; i++) mem1[i] = '0;
        test_reset();
        test_all_zero();
        test_all_ones();
        test_random_ready();
        test_restart();
        test_reset_mid();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
